div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 selects DIV, 0 selects DIVU; sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH bits: the dividend; sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH bits: the divisor; sampled with start.
REQ-008 The block SHALL have port annul, input, 1 bit: cancel the in-flight divide (exception or flush).
REQ-009 The block SHALL have port stall, output, 1 bit: drives the enables of the upstream pipeline registers low (stall) while asserted.
REQ-010 The block SHALL have port busy, output, 1 bit: high when state is CALC or DONE.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that the result is valid.
REQ-012 The block SHALL have port lo, output, WIDTH bits: the quotient.
REQ-013 The block SHALL have port hi, output, WIDTH bits: the remainder.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 The FSM SHALL follow these transitions:
- IDLE to CALC on start=1 and annul=0.
- CALC to DONE after exactly WIDTH iterations.
- DONE to IDLE unconditionally.
REQ-016 On accepting start, the block SHALL latch the magnitudes of a and b (two's-complement absolute value when is_signed=1, raw otherwise), both operand signs and is_signed, and SHALL clear the iteration counter.
REQ-017 Each CALC cycle SHALL perform one radix-2 restoring step: shift {rem,quo} left by 1, subtract the divisor from rem, keep the result if non-negative, and set the quotient LSB accordingly.
REQ-018 Timing SHALL be fixed: start sampled in cycle 0 means CALC occupies cycles 1..WIDTH, and DONE with done=1 falls in cycle WIDTH+1 (WIDTH=32 gives done in cycle 33).
REQ-019 stall SHALL equal (IDLE and start and not annul) or CALC; it SHALL be low in DONE so the consuming instruction advances that cycle.
REQ-020 lo and hi SHALL be registered, SHALL update only on entry to DONE, and SHALL hold their values at all other times.
REQ-021 Signed results SHALL apply these sign rules:
- Quotient is negated when the dividend sign differs from the divisor sign.
- Remainder takes the dividend sign.
REQ-022 Signed overflow SHALL give lo=0x80000000 and hi=0: dividend 0x80000000 divided by 0xFFFFFFFF.
REQ-023 Divide by zero SHALL still take full latency and SHALL give lo=all ones and hi=a as sampled.
REQ-024 start SHALL be ignored while busy=1, and no request SHALL be queued.
REQ-025 annul=1 in CALC or DONE SHALL force IDLE next cycle; no done pulse is produced and lo and hi are left unchanged.
REQ-026 When annul and start are both asserted in IDLE, annul SHALL win and no divide starts.
REQ-027 start SHALL be accepted in the cycle immediately following DONE, giving back-to-back divides.

Reset
REQ-028 rst=0 at a clock edge SHALL force state=IDLE, counter=0, lo=0, hi=0 and done=0; stall and busy are 0 from the following cycle.
REQ-029 rst=0 mid-operation SHALL abandon the divide with no done pulse, and no operand state SHALL survive reset.

Structure
REQ-030 FSM state encodings, WIDTH default and divide-by-zero quotient constant SHALL live in the shared CPU definitions package.
REQ-031 A single combinational sub-module div_step SHALL implement one shift/subtract/select iteration; sign fix-up SHALL stay in div_unit.
REQ-032 The block SHALL contain no latches and no asynchronous logic.

Verification
REQ-033 The bench SHALL cover an unsigned divide: a=100, b=7, is_signed=0, start at cycle 0 -> done only in cycle 33, lo=14, hi=2; stall high cycles 0..32, low in 33.
REQ-034 The bench SHALL cover a signed divide: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-035 The bench SHALL cover boundaries:
- Divide by zero: a=5, b=0 -> lo=0xFFFFFFFF, hi=5, done in cycle 33.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 The bench SHALL cover annul and ignored start:
- Prior result lo=14, hi=2; new start, annul=1 in cycle 10 -> IDLE in cycle 11, no done, lo=14, hi=2 held.
- start pulsed in cycle 5 of a divide -> ignored.
REQ-037 The bench SHALL cover reset and back-to-back operation:
- rst=0 in cycle 20 of a divide -> lo=0, hi=0, busy=0, no done.
- Second start in the cycle after done -> second result lands 34 cycles after the first.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the iterative divider: width default, FSM encoding,
// divide-by-zero quotient fill and the latched operand control payload.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Quotient of a divide by zero is every bit set to this value.
  localparam logic DIV_ZERO_QUO_BIT = 1'b1;

  typedef struct packed {
    logic sgn;
    logic a_neg;
    logic b_neg;
    logic b_zero;
  } div_ctrl_t;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_c,
  output logic [WIDTH-1:0] quo_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Top bit of diff is the borrow: set means shifted < divisor, so restore.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    quo_c   = {quo[WIDTH-2:0], ~diff[WIDTH]};
    rem_c   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider with fixed WIDTH+1 cycle latency,
// pipeline stall generation and annul/flush support.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q;
  div_state_e       state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  div_ctrl_t        ctrl_q;

  logic             accept_c;
  logic             last_iter_c;
  logic             finish_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] rem_c;
  logic [WIDTH-1:0] quo_c;
  logic             quo_neg_c;
  logic             rem_neg_c;
  logic [WIDTH-1:0] lo_c;
  logic [WIDTH-1:0] hi_c;

  assign accept_c    = (state_q == ST_IDLE) && start && !annul;
  assign last_iter_c = (count_q == CNT_W'(WIDTH - 1));
  assign finish_c    = (state_q == ST_CALC) && (state_d == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; annul pulls any active divide back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_CALC;
      ST_CALC: begin
        if (annul)            state_d = ST_IDLE;
        else if (last_iter_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall drops in DONE so the consuming instruction advances with the result.
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    case (state_q)
      ST_IDLE: stall = start & ~annul;
      ST_CALC: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      ST_DONE: busy = 1'b1;
      default: begin
        stall = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  assign a_neg_c = is_signed & a[WIDTH-1];
  assign b_neg_c = is_signed & b[WIDTH-1];
  assign a_mag_c = a_neg_c ? (~a + WIDTH'(1)) : a;
  assign b_mag_c = b_neg_c ? (~b + WIDTH'(1)) : b;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .divisor(divisor_q),
    .rem_c  (rem_c),
    .quo_c  (quo_c)
  );

  // Iteration datapath: load magnitudes on accept, step once per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      ctrl_q    <= '0;
    end else if (accept_c) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= a_mag_c;
      divisor_q <= b_mag_c;
      ctrl_q    <= '{sgn: is_signed, a_neg: a_neg_c, b_neg: b_neg_c, b_zero: (b == '0)};
    end else if (state_q == ST_CALC) begin
      count_q <= count_q + CNT_W'(1);
      rem_q   <= rem_c;
      quo_q   <= quo_c;
    end
  end

  // Sign fix-up applied to the final iteration's outputs.
  always_comb begin
    quo_neg_c = ctrl_q.sgn & (ctrl_q.a_neg ^ ctrl_q.b_neg);
    rem_neg_c = ctrl_q.sgn & ctrl_q.a_neg;
    hi_c      = rem_neg_c ? (~rem_c + WIDTH'(1)) : rem_c;
    if (ctrl_q.b_zero) lo_c = {WIDTH{DIV_ZERO_QUO_BIT}};
    else               lo_c = quo_neg_c ? (~quo_c + WIDTH'(1)) : quo_c;
  end

  // Results and done pulse are captured only on the CALC to DONE transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lo   <= '0;
      hi   <= '0;
      done <= 1'b0;
    end else begin
      done <= finish_c;
      if (finish_c) begin
        lo <= lo_c;
        hi <= hi_c;
      end
    end
  end

endmodule
